// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM state type, special key codes and the 4x4 matrix decode
// shared by the keypad front end.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;
    localparam logic [3:0] COL_INIT = 4'b1110;

    // Layout: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
    function automatic logic [3:0] code_of(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] code;
        code = 4'h0;
        case ({row_idx, col_idx})
            4'd0:  code = 4'h1;
            4'd1:  code = 4'h2;
            4'd2:  code = 4'h3;
            4'd3:  code = 4'hA;
            4'd4:  code = 4'h4;
            4'd5:  code = 4'h5;
            4'd6:  code = 4'h6;
            4'd7:  code = 4'hB;
            4'd8:  code = 4'h7;
            4'd9:  code = 4'h8;
            4'd10: code = 4'h9;
            4'd11: code = 4'hC;
            4'd12: code = KEY_STAR;
            4'd13: code = 4'h0;
            4'd14: code = KEY_HASH;
            4'd15: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// keypad_entry_if: keypad matrix pins plus the decoded key/confirm outputs.
interface keypad_entry_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] dout;
    logic       key_strobe;
    logic       confirm;

    modport master (output row, input col, dout, key_strobe, confirm);
    modport slave  (input row, output col, dout, key_strobe, confirm);
endinterface

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: free-running scan divider, one-cycle tick every SCAN_DIV clocks.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);
    localparam int W = $clog2(SCAN_DIV);

    logic [W-1:0] cnt_q;

    assign tick_o = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        cnt_q <= '0;
        else if (tick_o) cnt_q <= W'(SCAN_DIV - 1);
        else             cnt_q <= cnt_q - W'(1);
    end
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 keypad column scan, debounce and decode into a held code plus
// key_strobe / confirm pulses. Define KEYPAD_AUTOREPEAT_EN to re-emit held keys.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  SCAN     | rotate columns each tick until a row reads low
//  DEBOUNCE | column frozen, counting stable ticks of the latched row
//  PRESSED  | event emitted, waiting for all rows high
//  RELEASE  | counting stable released ticks before scanning again
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_TICKS = 250
) (
    input  logic          clk,
    input  logic          rst,
    keypad_entry_if.slave kp
);
    localparam int              CW       = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_DONE = CW'(DEBOUNCE_CNT);

    if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_TICKS < 1) begin : g_param_err
        $error("keypad_entry: illegal parameter value");
    end

    logic            tick;
    logic [3:0]      row_m_q, row_s_q;
    kp_state_t       state_q, state_d;
    logic [3:0]      col_q, col_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [1:0]      row_idx_q, row_idx_d;
    logic [3:0]      dout_q, dout_d;
    logic            strobe_q, strobe_d;
    logic            confirm_q, confirm_d;
    logic            low_any, fire;
    logic [1:0]      low_idx, col_idx;
    logic [3:0]      ev_code;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int            RW       = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW-1:0] REP_DONE = RW'(REPEAT_TICKS);
    logic [RW-1:0]            rep_q, rep_d;
`endif

    keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    assign low_any = (row_s_q != 4'hF);
    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        low_idx = 2'd3;
        if (!row_s_q[2]) low_idx = 2'd2;
        if (!row_s_q[1]) low_idx = 2'd1;
        if (!row_s_q[0]) low_idx = 2'd0;
    end

    always_comb begin
        case (col_q)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        row_idx_d = row_idx_q;
        dout_d    = dout_q;
        strobe_d  = 1'b0;
        confirm_d = 1'b0;
        fire      = 1'b0;
        ev_code   = 4'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d     = rep_q;
`endif
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (!low_any) begin
                        col_d = {col_q[2:0], col_q[3]};
                    end else begin
                        row_idx_d = low_idx;
                        cnt_d     = CNT_ONE;
                        if (CNT_ONE >= CNT_DONE) begin
                            state_d = PRESSED;
                            cnt_d   = '0;
                            fire    = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (low_any && low_idx == row_idx_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_DONE) begin
                            state_d = PRESSED;
                            cnt_d   = '0;
                            fire    = 1'b1;
                        end
                    end else begin
                        state_d = SCAN;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (!low_any) begin
                        cnt_d   = CNT_ONE;
                        state_d = RELEASE;
                        if (CNT_ONE >= CNT_DONE) begin
                            state_d = SCAN;
                            cnt_d   = '0;
                        end
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else begin
                        rep_d = rep_q + RW'(1);
                        if (rep_d == REP_DONE) begin
                            rep_d = '0;
                            fire  = (code_of(row_idx_q, col_idx) != KEY_HASH);
                        end
                    end
`endif
                end
                RELEASE: begin
                    if (!low_any) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_DONE) begin
                            state_d = SCAN;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end
                end
            endcase
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        if (state_d == PRESSED && state_q != PRESSED) rep_d = '0;
`endif
        // '#' only confirms; it never disturbs the held code
        if (fire) begin
            ev_code = code_of(row_idx_d, col_idx);
            if (ev_code == KEY_HASH) begin
                confirm_d = 1'b1;
            end else begin
                dout_d   = ev_code;
                strobe_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_m_q   <= 4'hF;
            row_s_q   <= 4'hF;
            state_q   <= SCAN;
            col_q     <= COL_INIT;
            cnt_q     <= '0;
            row_idx_q <= 2'd0;
            dout_q    <= 4'h0;
            strobe_q  <= 1'b0;
            confirm_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            row_m_q   <= kp.row;
            row_s_q   <= row_m_q;
            state_q   <= state_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            row_idx_q <= row_idx_d;
            dout_q    <= dout_d;
            strobe_q  <= strobe_d;
            confirm_q <= confirm_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

    assign kp.col        = col_q;
    assign kp.dout       = dout_q;
    assign kp.key_strobe = strobe_q;
    assign kp.confirm    = confirm_q;
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: keypad matrix model driving keypad_entry, events checked via a scoreboard.
module tb_keypad_entry;
    logic clk;
    logic rst;
    logic [15:0] keys;
    int n_tests;
    int n_fail;
    logic [5:0] sb[$];
    logic [3:0] exp_dout;
    logic       prev_pulse;

    keypad_entry_if kp_if ();

    keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_CNT(3), .REPEAT_TICKS(5)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        logic [3:0] r;
        r = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (keys[ri*4+ci] && !kp_if.col[ci]) r[ri] = 1'b0;
        kp_if.row = r;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_key(input logic [3:0] code);
        sb.push_back({2'b10, code});
        exp_dout = code;
    endtask

    task automatic push_hash();
        sb.push_back({2'b01, exp_dout});
    endtask

    function automatic logic [3:0] colmask(input int c);
        logic [3:0] m;
        m = 4'b0001 << c;
        return ~m;
    endfunction

    task automatic wait_col(input logic [3:0] target);
        for (int i = 0; i < 64 && kp_if.col !== target; i++) @(negedge clk);
        check("col_wait", kp_if.col, target);
    endtask

    task automatic press(input int r, input int c, input int hold, input int rel);
        keys[r*4+c] = 1'b1;
        wait_col(colmask(c));
        repeat (hold) @(negedge clk);
        check("col_frozen", kp_if.col, colmask(c));
        keys = '0;
        repeat (rel) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [5:0] exp_ev;
        if (!rst) begin
            prev_pulse <= 1'b0;
        end else begin
            if (prev_pulse) check("pulse_width", {kp_if.key_strobe, kp_if.confirm}, 2'b00);
            if (kp_if.key_strobe || kp_if.confirm) begin
                exp_ev = (sb.size() > 0) ? sb.pop_front() : 6'h00;
                check("event", {kp_if.key_strobe, kp_if.confirm, kp_if.dout}, exp_ev);
            end
            prev_pulse <= kp_if.key_strobe | kp_if.confirm;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev_col;
        int since, nchg;
        n_tests  = 0;
        n_fail   = 0;
        keys     = '0;
        exp_dout = 4'h0;
        rst      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_col", kp_if.col, 4'b1110);
        check("rst_dout", kp_if.dout, 4'h0);
        check("rst_strobe", kp_if.key_strobe, 1'b0);
        check("rst_confirm", kp_if.confirm, 1'b0);
        rst = 1'b1;

        // idle rotation
        prev_col = 4'b1110;
        since = 0;
        nchg  = 0;
        repeat (40) begin
            @(negedge clk);
            since++;
            if (kp_if.col !== prev_col) begin
                check("col_rot", kp_if.col, {prev_col[2:0], prev_col[3]});
                if (nchg > 0) check("col_period", since, 4);
                prev_col = kp_if.col;
                since = 0;
                nchg++;
            end
        end
        check("col_changes", nchg >= 9, 1'b1);

        push_key(4'h5);
        press(1, 1, 24, 24);
        check("dout_5", kp_if.dout, 4'h5);

        push_hash();
        press(3, 2, 24, 24);
        check("dout_after_hash", kp_if.dout, 4'h5);

        // press bounce then release bounce on '1'
        push_key(4'h1);
        keys[0] = 1'b1;
        wait_col(4'b1110);
        repeat (4) @(negedge clk);
        keys[0] = 1'b0;
        repeat (4) @(negedge clk);
        keys[0] = 1'b1;
        repeat (40) @(negedge clk);
        check("col_frozen_1", kp_if.col, 4'b1110);
        keys[0] = 1'b0;
        repeat (4) @(negedge clk);
        keys[0] = 1'b1;
        repeat (4) @(negedge clk);
        keys[0] = 1'b0;
        for (int i = 0; i < 40 && kp_if.col === 4'b1110; i++) @(negedge clk);
        check("rescan", kp_if.col, 4'b1101);
        check("dout_1", kp_if.dout, 4'h1);

        // 2-tick glitch: no event
        keys[0] = 1'b1;
        wait_col(4'b1110);
        repeat (8) @(negedge clk);
        keys[0] = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch_dout", kp_if.dout, 4'h1);

        // two keys in one column, lowest row wins; later key ignored
        push_key(4'h6);
        keys[1*4+2] = 1'b1;
        keys[2*4+2] = 1'b1;
        wait_col(4'b1011);
        repeat (24) @(negedge clk);
        keys[0*4+2] = 1'b1;
        repeat (12) @(negedge clk);
        check("col_frozen_multi", kp_if.col, 4'b1011);
        keys = '0;
        repeat (30) @(negedge clk);
        check("dout_6", kp_if.dout, 4'h6);

        push_key(4'hE);
        press(3, 0, 24, 24);
        check("dout_star", kp_if.dout, 4'hE);
        push_key(4'h0);
        press(3, 1, 24, 24);
        check("dout_0", kp_if.dout, 4'h0);

        // long hold of '7'
        push_key(4'h7);
`ifdef KEYPAD_AUTOREPEAT_EN
        push_key(4'h7);
        push_key(4'h7);
        push_key(4'h7);
`endif
        press(2, 0, 80, 30);
        check("dout_7", kp_if.dout, 4'h7);

        // reset during DEBOUNCE of 'D'
        keys[15] = 1'b1;
        wait_col(4'b0111);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_col", kp_if.col, 4'b1110);
        check("mid_rst_dout", kp_if.dout, 4'h0);
        check("mid_rst_pulses", {kp_if.key_strobe, kp_if.confirm}, 2'b00);
        keys = '0;
        exp_dout = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_dout", kp_if.dout, 4'h0);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
